// File: rtl/gray_counter_ctrl.sv
// Sequencer for an attached W-bit gray counter: clears it, gates its count enable
// for a one-shot length or free-run, decodes gray to binary and polices legal steps.
module gray_counter_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         one_shot,
  input  logic [W-1:0] len,
  input  logic [W-1:0] cnt,
  output logic         ce,
  output logic         cnt_rst_n,
  output logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         wrap,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] len_q;
  logic [W-1:0] prev_q;
  logic         one_shot_q;
  logic         at_len;
  logic         at_max;
  logic         start_ok;
  logic         moved;
  logic         step_bad;

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(cnt >> i);
    end
  end

  assign at_len    = (bin == len_q);
  assign at_max    = &bin;
  assign start_ok  = (state == IDLE) && start;
  assign moved     = (cnt != prev_q);
  assign cnt_rst_n = ~(rst | (state == CLEAR));

  always_comb begin
    unique case (state)
      RUN:       step_bad = moved && ($countones(cnt ^ prev_q) != 1);
      IDLE, DONE: step_bad = moved;
      default:   step_bad = 1'b0;
    endcase
  end

  // NOTE: every output and next_state gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ce        = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (stop)             state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = RUN;
      end
      RUN: begin
        ce = ~stop & ~(one_shot_q & at_len);
        if (stop)                      state_nxt = IDLE;
        else if (one_shot_q && at_len) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset is synchronous, so mask strobes during the reset cycle itself.
    if (rst) begin
      ce   = 1'b0;
      done = 1'b0;
    end
  end

  assign busy = (state != IDLE) && !rst;
  assign wrap = ce & ~one_shot_q & at_max;

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      one_shot_q <= 1'b0;
      prev_q     <= '0;
      err        <= 1'b0;
    end else begin
      state  <= state_nxt;
      prev_q <= cnt;
      if (start_ok) begin
        len_q      <= len;
        one_shot_q <= one_shot;
        err        <= 1'b0;
      end else if (step_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Bench for gray_counter_ctrl: a behavioural gray counter closes the loop, stimulus
// queues expected per-sequence summaries and snapshots, a monitor pops and compares.
module tb_gray_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       one_shot;
  logic [3:0] len;
  logic [3:0] cnt;
  logic       ce;
  logic       cnt_rst_n;
  logic [3:0] bin;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       err;

  logic [3:0] cnt_reg = 4'b0110;
  logic       inject_en;
  logic [3:0] inject_val;
  logic       finish_req;

  typedef struct {
    int         busy_c;
    int         clear_c;
    int         run_c;
    int         ce_c;
    int         done_c;
    int         wrap_c;
    logic [3:0] fin_bin;
    logic       fin_err;
  } seq_t;

  typedef struct {
    logic       busy;
    logic       err;
    logic [3:0] bin;
  } probe_t;

  seq_t   seq_q[$];
  probe_t probe_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  gray_counter_ctrl #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .one_shot  (one_shot),
    .len       (len),
    .cnt       (cnt),
    .ce        (ce),
    .cnt_rst_n (cnt_rst_n),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gray_next(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    b = b + 4'd1;
    return b ^ (b >> 1);
  endfunction

  // Attached counter model, with a bench override for fault injection.
  always @(posedge clk) begin
    if (inject_en)       cnt_reg <= inject_val;
    else if (!cnt_rst_n) cnt_reg <= 4'b0000;
    else if (ce)         cnt_reg <= gray_next(cnt_reg);
  end
  assign cnt = cnt_reg;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input int busy_c, input int clear_c, input int run_c,
                            input int ce_c, input int done_c, input int wrap_c,
                            input logic [3:0] fin_bin, input logic fin_err);
    seq_t s;
    s.busy_c  = busy_c;
    s.clear_c = clear_c;
    s.run_c   = run_c;
    s.ce_c    = ce_c;
    s.done_c  = done_c;
    s.wrap_c  = wrap_c;
    s.fin_bin = fin_bin;
    s.fin_err = fin_err;
    seq_q.push_back(s);
  endtask

  task automatic probe(input logic b, input logic e, input logic [3:0] bn);
    probe_t p;
    p.busy = b;
    p.err  = e;
    p.bin  = bn;
    probe_q.push_back(p);
  endtask

  task automatic pulse_start(input logic os, input logic [3:0] l);
    one_shot = os;
    len      = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    int   busy_c, clear_c, run_c, ce_c, done_c, wrap_c;
    logic in_seq;
    seq_t s;
    probe_t p;
    in_seq = 1'b0;
    {busy_c, clear_c, run_c, ce_c, done_c, wrap_c} = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outs", int'({ce, cnt_rst_n, busy, done, wrap, err}), 0);
        in_seq = 1'b0;
      end else begin
        if (busy) begin
          busy_c++;
          if (!cnt_rst_n)          clear_c++;
          if (cnt_rst_n && !done)  run_c++;
          if (ce)                  ce_c++;
          if (done)                done_c++;
          if (wrap)                wrap_c++;
        end
        if (wrap) check("wrap_at_max", int'({ce, bin}), 31);
        if (in_seq && !busy) begin
          if (seq_q.size() == 0) begin
            check("seq_unexpected", 1, 0);
          end else begin
            s = seq_q.pop_front();
            check("seq_busy_cycles",  busy_c,  s.busy_c);
            check("seq_clear_cycles", clear_c, s.clear_c);
            check("seq_run_cycles",   run_c,   s.run_c);
            check("seq_ce_cycles",    ce_c,    s.ce_c);
            check("seq_done_cycles",  done_c,  s.done_c);
            check("seq_wrap_count",   wrap_c,  s.wrap_c);
            check("seq_final_bin",    int'(bin), int'(s.fin_bin));
            check("seq_final_err",    int'(err), int'(s.fin_err));
          end
          {busy_c, clear_c, run_c, ce_c, done_c, wrap_c} = '0;
        end
        in_seq = busy;
      end
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        check("probe_busy", int'(busy), int'(p.busy));
        check("probe_err",  int'(err),  int'(p.err));
        check("probe_bin",  int'(bin),  int'(p.bin));
      end
      if (finish_req) begin
        check("scoreboard_drained", seq_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    one_shot   = 1'b0;
    len        = 4'd0;
    inject_en  = 1'b1;
    inject_val = 4'b0110;
    finish_req = 1'b0;

    // Reset hold with a nonzero counter value; gray 0110 decodes to 4.
    repeat (9) tick();
    probe(1'b0, 1'b0, 4'd4);
    inject_val = 4'b0000;
    tick();
    rst       = 1'b0;
    inject_en = 1'b0;
    tick();

    // One-shot len=0 from a cleared counter.
    expect_seq(3, 1, 1, 0, 1, 0, 4'd0, 1'b0);
    pulse_start(1'b1, 4'd0);
    repeat (4) tick();

    // One-shot len=5: counter stops holding gray 0111.
    expect_seq(8, 1, 6, 5, 1, 0, 4'd5, 1'b0);
    pulse_start(1'b1, 4'd5);
    repeat (9) tick();

    // Free-run for 40 counts, len ignored; two wraps, stop at bin 8.
    expect_seq(43, 2, 41, 40, 0, 2, 4'd8, 1'b0);
    pulse_start(1'b0, 4'd3);
    tick();
    tick();
    repeat (40) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (2) tick();

    // One-shot len=10 aborted by stop at bin 3.
    expect_seq(6, 2, 4, 3, 0, 0, 4'd3, 1'b0);
    pulse_start(1'b1, 4'd10);
    tick();
    tick();
    repeat (3) tick();
    probe(1'b1, 1'b0, 4'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (2) tick();

    // Counter moves while idle (0010 -> 1010): err, bin 12.
    inject_en  = 1'b1;
    inject_val = 4'b1010;
    tick();
    tick();
    probe(1'b0, 1'b1, 4'd12);

    // Start with counter stuck at 1010 for a while; start and mode changes in RUN ignored.
    expect_seq(10, 4, 5, 4, 1, 0, 4'd4, 1'b0);
    pulse_start(1'b1, 4'd4);
    tick();
    tick();
    inject_en = 1'b0;
    tick();
    tick();
    tick();
    start    = 1'b1;
    one_shot = 1'b0;
    len      = 4'd9;
    tick();
    start    = 1'b0;
    repeat (5) tick();

    // Illegal two-bit step 0001 -> 0010 during RUN; err sticks into IDLE.
    expect_seq(9, 2, 6, 5, 1, 0, 4'd6, 1'b1);
    pulse_start(1'b1, 4'd6);
    tick();
    tick();
    tick();
    inject_en  = 1'b1;
    inject_val = 4'b0010;
    tick();
    inject_en  = 1'b0;
    probe(1'b1, 1'b0, 4'd3);
    tick();
    probe(1'b1, 1'b1, 4'd4);
    repeat (5) tick();
    probe(1'b0, 1'b1, 4'd6);
    tick();

    // Next accepted start clears err.
    expect_seq(4, 2, 1, 0, 1, 0, 4'd0, 1'b0);
    pulse_start(1'b1, 4'd0);
    repeat (5) tick();

    finish_req = 1'b1;
    repeat (5) tick();
  end

endmodule

// File: doc/gray_counter_ctrl.md
Name: gray_counter_ctrl

Overview:
Sequencer for a W-bit gray_counter instance. It clears the counter and gates its ce for either a programmed number of counts (one-shot) or continuously (free-run). It converts the returned gray value to binary for the surrounding logic. It also checks that the counter steps legally (one bit change per increment, no change while idle).

Parameters:
W, 4, counter width in bits; must match the attached gray_counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active high.
start  in  1  begin a sequence; sampled only in IDLE.
stop  in  1  abort the sequence; sampled in CLEAR and RUN.
one_shot  in  1  1 = stop at len, 0 = free-run with wrap; latched on start.
len  in  W  terminal binary count for one-shot; latched on start.
cnt  in  W  gray value from the counter.
ce  out  1  count enable to the counter.
cnt_rst_n  out  1  active-low clear to the counter.
bin  out  W  gray-to-binary conversion of cnt; combinational.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at one-shot completion.
wrap  out  1  one-cycle pulse in free-run when the count rolls over.
err  out  1  sticky step-error flag; cleared on start or rst.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; len_q=0, one_shot_q=0, err=0, prev_q=0.
  - ce=0, done=0, wrap=0, busy=0.
  - cnt_rst_n = ~(rst | state==CLEAR), combinational, so the counter is also cleared while rst is high.
- bin[W-1] = cnt[W-1]; bin[i] = bin[i+1] ^ cnt[i].
- IDLE:
  - ce=0.
  - start=1 -> CLEAR; latch len_q and one_shot_q; clear err.
  - stop is ignored in IDLE.
- CLEAR:
  - cnt_rst_n=0, ce=0.
  - Stays in CLEAR while cnt!=0.
  - cnt==0 -> RUN.
  - stop=1 -> IDLE, which takes priority.
- RUN:
  - ce = ~stop & ~(one_shot_q & bin==len_q), combinational.
  - stop=1 -> IDLE next cycle, with ce=0 in the stop cycle.
  - one_shot_q and bin==len_q -> DONE. The counter holds at len_q because ce=0 in that cycle.
  - len_q=0: ce is never asserted; RUN lasts exactly one cycle.
  - Free-run: wrap = ce & (bin == 2^W-1). The counter wraps to 0 and RUN continues until stop.
- DONE:
  - done=1, ce=0, busy=1 for one cycle, then IDLE.
  - start during DONE is ignored.
- start while busy is ignored; len and one_shot changes while busy have no effect.
- Step checker:
  - prev_q <= cnt every cycle.
  - err is set if cnt != prev_q with popcount(cnt ^ prev_q) != 1 in RUN.
  - err is set if cnt != prev_q in IDLE or DONE (the counter moved without ce).
  - CLEAR is exempt from checking.
  - err holds until the next accepted start or rst.
- Outputs are valid after each posedge; no other latency.

Test Plan:
- Reset hold: rst=1 for 10 cycles, cnt=4'b0110 -> cnt_rst_n=0, ce=0, busy=0, done=0, err=0 throughout.
- One-shot len=5, counter idle at 0, start pulsed one cycle:
  - CLEAR for 1 cycle.
  - RUN for 6 cycles, ce=1 for exactly 5 of them.
  - cnt sequence 0000,0001,0011,0010,0110,0111; holds at 0111 (bin=5).
  - done=1 for 1 cycle; busy high for 8 cycles.
- One-shot len=0 -> CLEAR 1 cycle, RUN 1 cycle with ce=0, then done; total busy 3 cycles.
- Free-run W=4 for 40 cycles, then stop:
  - wrap pulses exactly twice, each in a cycle with bin=15 and ce=1.
  - ce=0 in the stop cycle; IDLE next cycle.
- Stop mid-run at bin=3 -> ce=0 in the same cycle, busy=0 next cycle, done never asserted.
- Start issued with counter at 1010 -> CLEAR holds until cnt=0, then RUN; start re-pulsed during RUN has no effect.
- Error injection:
  - Bench forces cnt 0001->0010 during RUN -> err=1 next cycle, sticky through IDLE; the next start clears it.
  - Bench changes cnt while in IDLE -> err=1.
